// File: rtl/program_counter_stack.sv
// program_counter_stack: SAP program counter with call/ret return-address stack and sticky stack traps.
// Define PC_RELATIVE_JUMP_EN to add the jump_rel port for PC-relative jumps.
module program_counter_stack #(
  parameter int ADDR_WIDTH  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 clear,
  input  logic                                 enable,
  input  logic                                 jump_n,
  input  logic                                 call_n,
  input  logic                                 ret_n,
`ifdef PC_RELATIVE_JUMP_EN
  input  logic                                 jump_rel,
`endif
  input  logic [ADDR_WIDTH-1:0]                bus_in,
  input  logic                                 bus_enable_n,
  output logic [ADDR_WIDTH-1:0]                instruction_pointer,
  output logic [ADDR_WIDTH-1:0]                bus_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_count,
  output logic                                 stack_full,
  output logic                                 stack_empty,
  output logic                                 stack_overflow,
  output logic                                 stack_underflow
);
  localparam int CW = $clog2(STACK_DEPTH+1);
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc, jump_tgt;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_m1;
  logic                  ovf_q, ovf_d, unf_q, unf_d, push;
  // Sized to the full count range so the count indexes it without width games.
  logic [ADDR_WIDTH-1:0] stack_q [2**CW];
  assign pc_inc = pc_q + ADDR_WIDTH'(1);
  assign cnt_m1 = cnt_q - CW'(1);
`ifdef PC_RELATIVE_JUMP_EN
  assign jump_tgt = jump_rel ? pc_q + bus_in : bus_in;
`else
  assign jump_tgt = bus_in;
`endif
  assign stack_full  = cnt_q == CW'(STACK_DEPTH);
  assign stack_empty = cnt_q == '0;
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (!ret_n) begin
      if (stack_empty) unf_d = 1'b1;
      else begin
        pc_d  = stack_q[cnt_m1];
        cnt_d = cnt_m1;
      end
    end else if (!call_n) begin
      if (stack_full) ovf_d = 1'b1;
      else begin
        push  = 1'b1;
        pc_d  = bus_in;
        cnt_d = cnt_q + CW'(1);
      end
    end else if (!jump_n) pc_d = jump_tgt;
    else if (enable) pc_d = pc_inc;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      pc_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!clear && push) stack_q[cnt_q] <= pc_inc;
  end
  assign instruction_pointer = pc_q;
  assign bus_out             = bus_enable_n ? 'z : pc_q;
  assign stack_count         = cnt_q;
  assign stack_overflow      = ovf_q;
  assign stack_underflow     = unf_q;
endmodule

// File: tb/tb_program_counter_stack.sv
// tb_program_counter_stack: directed plus random stimulus against a queue-based PC/stack model.
module tb_program_counter_stack;
  logic       clk = 1'b0;
  logic       clear = 1'b1, enable = 1'b0, jump_n = 1'b1, call_n = 1'b1, ret_n = 1'b1;
  logic       bus_enable_n = 1'b0;
  logic [3:0] bus_in = '0;
  logic [3:0] instruction_pointer, bus_out;
  logic [2:0] stack_count;
  logic       stack_full, stack_empty, stack_overflow, stack_underflow;
  int checks = 0, failures = 0;
  int m_pc = 0;
  bit m_ovf = 0, m_unf = 0;
  int m_stk[$];
  always #5 clk = ~clk;
  program_counter_stack #(.ADDR_WIDTH(4), .STACK_DEPTH(4)) dut (
    .clk(clk), .clear(clear), .enable(enable), .jump_n(jump_n), .call_n(call_n), .ret_n(ret_n),
`ifdef PC_RELATIVE_JUMP_EN
    .jump_rel(1'b0),
`endif
    .bus_in(bus_in), .bus_enable_n(bus_enable_n), .instruction_pointer(instruction_pointer),
    .bus_out(bus_out), .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
  );
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic clr, input logic r, input logic c, input logic j,
                      input logic e, input logic be, input logic [3:0] b);
    clear = clr; ret_n = r; call_n = c; jump_n = j; enable = e; bus_enable_n = be; bus_in = b;
    @(posedge clk);
    if (clr) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (!r) begin
      if (m_stk.size() == 0) m_unf = 1;
      else m_pc = m_stk.pop_back();
    end else if (!c) begin
      if (m_stk.size() == 4) m_ovf = 1;
      else begin
        m_stk.push_back((m_pc + 1) % 16);
        m_pc = b;
      end
    end else if (!j) m_pc = b;
    else if (e) m_pc = (m_pc + 1) % 16;
    #1;
    check("pc", {4'h0, instruction_pointer}, 8'(m_pc));
    check("count", {5'h0, stack_count}, 8'(m_stk.size()));
    check("full", {7'h0, stack_full}, {7'h0, m_stk.size() == 4});
    check("empty", {7'h0, stack_empty}, {7'h0, m_stk.size() == 0});
    check("overflow", {7'h0, stack_overflow}, {7'h0, m_ovf});
    check("underflow", {7'h0, stack_underflow}, {7'h0, m_unf});
    if (be) check("bus_z", {4'h0, bus_out}, {4'h0, 4'bzzzz});
    else check("bus_out", {4'h0, bus_out}, 8'(m_pc));
  endtask
  initial begin
    step(1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 1, i[0], 0);
    step(0, 1, 1, 0, 0, 0, 3);
    step(0, 1, 0, 1, 0, 0, 9);
    step(0, 1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 1, 0, 1, 0, 0, 4'(i));
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 15);
    step(0, 1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0, 15);
    step(0, 1, 0, 1, 0, 0, 6);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 6);
    step(0, 1, 0, 1, 0, 0, 2);
    step(0, 0, 0, 0, 1, 0, 9);
    step(0, 0, 0, 0, 1, 0, 9);
    step(0, 1, 0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 0, 0, 2);
    step(1, 0, 0, 0, 1, 0, 5);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 4'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
Parametrised next-generation program counter for the SAP CPU.
- Adds configurable address width, call/return operations and an internal return-address stack to the base increment/jump behaviour.
- Sits between the control sequencer (strobes) and the shared data bus (bus_in for jump/call targets, bus_out for PC readout).
- Reports stack status so the controller can trap on overflow or underflow.

Parameters:
ADDR_WIDTH, 4, width of the program counter, the bus and the stack entries (>=2)
STACK_DEPTH, 4, number of return-address entries (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
clear  input  1  synchronous active-high reset
enable  input  1  count enable; PC increments when no other operation is active
jump_n  input  1  active-low load of PC from bus_in
call_n  input  1  active-low call: push PC+1, load PC from bus_in
ret_n  input  1  active-low return: pop stack top into PC
bus_in  input  ADDR_WIDTH  jump/call target from the bus
bus_enable_n  input  1  active-low bus drive enable
instruction_pointer  output  ADDR_WIDTH  current PC, always driven
bus_out  output  ADDR_WIDTH  PC onto the shared bus; high-impedance when bus_enable_n=1
stack_count  output  $clog2(STACK_DEPTH+1)  entries in use
stack_full  output  1  stack_count==STACK_DEPTH
stack_empty  output  1  stack_count==0
stack_overflow  output  1  sticky: call attempted while full
stack_underflow  output  1  sticky: ret attempted while empty

Behaviour:
- Reset (clear=1 at posedge), overriding all other inputs:
  - PC=0, stack_count=0, stack_overflow=0, stack_underflow=0.
  - Stack entry contents are don't-care.
- Priority per cycle when clear=0: ret_n=0 > call_n=0 > jump_n=0 > enable=1 > hold. Exactly one operation executes per edge.
- Ret:
  - Not empty: PC <= stack[top], count decrements.
  - Empty: PC holds, count stays 0, stack_underflow <= 1.
- Call:
  - Not full: stack[count] <= (PC+1) mod 2^ADDR_WIDTH, PC <= bus_in, count increments.
  - Full: PC holds, stack untouched, stack_overflow <= 1.
- Jump: PC <= bus_in. Stack unaffected.
- Increment: PC <= (PC+1) mod 2^ADDR_WIDTH; all-ones wraps to 0.
- Hold: enable=0 and no strobe leaves PC unchanged.
- Latency:
  - Every operation takes effect on the edge where its strobe is sampled.
  - instruction_pointer shows the new value after that edge.
  - Strobes are level-sampled; a strobe held N cycles executes N times.
- bus_out: combinational from instruction_pointer gated by bus_enable_n; no register, no effect on state.
- stack_full, stack_empty and stack_count are combinational from registered count.
- Sticky flags are cleared only by clear.
- Call at PC=all-ones pushes 0 as the return address.
- Reset asserted mid-call/ret sequence discards the stack; no partial update.

Optional Feature:
PC_RELATIVE_JUMP_EN
- Defined: adds input port jump_rel (1 bit). When jump_n=0 and jump_rel=1, PC <= (PC + sign-extended bus_in) mod 2^ADDR_WIDTH. When jump_rel=0, the jump is absolute. jump_rel is ignored for call, ret and increment.
- Undefined: port absent; all jumps absolute.

Test Plan:
- Clear then enable=1 for 5 cycles (ADDR_WIDTH=4) -> PC 0,1,2,3,4,5; stack_empty=1; bus_out=PC with bus_enable_n=0 and Z with bus_enable_n=1.
- PC=3, call_n=0 one cycle with bus_in=9, then enable 2 cycles, then ret_n=0 one cycle -> PC 9,10,11,4; stack_count 1,1,1,0.
- STACK_DEPTH=4: five consecutive calls -> count saturates at 4, stack_full=1, stack_overflow=1 after the fifth, PC unchanged on the fifth; four rets restore return addresses in LIFO order; a fifth ret sets stack_underflow=1 with PC held.
- PC=15, enable=1 -> PC=0. PC=15, call to 6, then ret -> PC returns to 0.
- Simultaneous ret_n=0, call_n=0, jump_n=0 with one stack entry (value 7) -> ret wins, PC=7, count 0. Same with empty stack -> underflow set, PC held, no call performed.
- With PC_RELATIVE_JUMP_EN: PC=10, jump_rel=1, bus_in=4'b1110 (-2) -> PC=8; PC=14, bus_in=3 -> PC=1 (wrap). Clear during stack_count=2 -> count 0, both sticky flags 0.
